// File: rtl/rca_sub_pkg.sv
// Shared types and helpers for the sequential ripple-slice subtractor.
package rca_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Number of ripple slices (and RUN cycles) needed for one operation.
    function automatic int unsigned nslice(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/sub_slice_2op.sv
// Combinational SLICE-bit ripple subtractor built from full-subtractor cells.
module sub_slice_2op #(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] diff,
    output logic             bout
);

    logic [SLICE:0] bw;

    assign bw[0] = bin;

    for (genvar i = 0; i < SLICE; i++) begin : g_cell
        // Full subtractor: borrow when a < b + borrow-in at this bit.
        assign diff[i]  = a[i] ^ b[i] ^ bw[i];
        assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end

    assign bout = bw[SLICE];

endmodule

// File: rtl/rca_2op_sub_seq.sv
// Multi-cycle A - B - Bin, one SLICE-bit ripple slice per clock, LSB first,
// with the borrow carried between slices in a register. Also yields the
// zero / signed-less-than / signed-overflow flags of the full difference.
module rca_2op_sub_seq
    import rca_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   D,
    output logic             zero,
    output logic             lt_s,
    output logic             ovf
);

    localparam int unsigned NSLICE = nslice(WIDTH, SLICE);
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("rca_2op_sub_seq: WIDTH must be a multiple of SLICE");
    end

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             borrow_q;
    logic [WIDTH:0]   d_q;
    logic             zero_acc_q;
    logic             zero_q, lt_s_q, ovf_q;

    logic [SLICE-1:0] a_sl, b_sl, diff_sl;
    logic             bout_sl;
    logic             last_slice;
    logic             slice_zero;
    logic [WIDTH:0]   d_next;
    logic             ovf_next;

    // Operand mux: pick slice k of the latched operands for the shared slice.
    assign a_sl       = a_q[int'(k_q) * SLICE +: SLICE];
    assign b_sl       = b_q[int'(k_q) * SLICE +: SLICE];
    assign last_slice = (k_q == KLAST);
    assign slice_zero = (diff_sl == '0);

    sub_slice_2op #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .bin  (borrow_q),
        .diff (diff_sl),
        .bout (bout_sl)
    );

    // Merge this cycle's slice into the accumulated difference; the top bit
    // ends up holding the final borrow once the last slice is written.
    always_comb begin
        d_next                             = d_q;
        d_next[int'(k_q) * SLICE +: SLICE] = diff_sl;
        d_next[WIDTH]                      = bout_sl;
        ovf_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (d_next[WIDTH-1] != a_q[WIDTH-1]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs depend on state only.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath: latch operands, ripple one slice per RUN cycle, register flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            borrow_q   <= 1'b0;
            d_q        <= '0;
            zero_acc_q <= 1'b0;
            zero_q     <= 1'b0;
            lt_s_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= B;
                        borrow_q   <= Bin;
                        k_q        <= '0;
                        d_q        <= '0;
                        zero_acc_q <= 1'b1;
                    end
                end
                RUN: begin
                    d_q        <= d_next;
                    borrow_q   <= bout_sl;
                    zero_acc_q <= zero_acc_q & slice_zero;
                    k_q        <= k_q + KW'(1);
                    if (last_slice) begin
                        zero_q <= zero_acc_q & slice_zero;
                        ovf_q  <= ovf_next;
                        lt_s_q <= d_next[WIDTH-1] ^ ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign D    = d_q;
    assign zero = zero_q;
    assign lt_s = lt_s_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca_2op_sub_seq.sv
// Directed bench for rca_2op_sub_seq with the default 16/8 configuration.
module tb_rca_2op_sub_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   D;
    logic         zero, lt_s, ovf;

    int total;
    int bad;

    rca_2op_sub_seq #(
        .WIDTH (W),
        .SLICE (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .zero      (zero),
        .lt_s      (lt_s),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation, wait (bounded) for out_valid, capture, then handshake.
    // lat = number of edges after the accept edge until out_valid; 0 = timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output logic [W:0] d, output logic z, output logic l,
                          output logic o, output int lat);
        @(negedge clk);
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) @(posedge clk);
            else @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        d = D; z = zero; l = lt_s; o = ovf;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (out_valid !== 1'b0 || D !== 17'h0 || zero !== 1'b0 || lt_s !== 1'b0 ||
            ovf !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: out_valid=%b D=%h zero=%b lt_s=%b ovf=%b in_ready=%b, want 0 0 0 0 0 1",
                     out_valid, D, zero, lt_s, ovf, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [W:0] d;
        logic       z, l, o;
        int         lat;
        // Basic subtract and latency.
        run_op(16'h1234, 16'h0034, 1'b0, d, z, l, o, lat);
        total++;
        if (lat !== 2) begin
            bad++; $display("FAIL basic_latency: got %0d want 2", lat);
        end
        total++;
        if ({d, z, l, o} !== {17'h01200, 3'b000}) begin
            bad++; $display("FAIL basic: D=%h z%b l%b o%b want D=01200 z0 l0 o0", d, z, l, o);
        end
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL after_handshake: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        // Wrap-around with borrow out.
        run_op(16'h0000, 16'h0001, 1'b0, d, z, l, o, lat);
        total++;
        if ({d, z, l, o} !== {17'h1FFFF, 3'b010}) begin
            bad++; $display("FAIL wrap: D=%h z%b l%b o%b want D=1FFFF z0 l1 o0", d, z, l, o);
        end
        // Borrow ripples from slice 0 into slice 1.
        run_op(16'h0100, 16'h0001, 1'b0, d, z, l, o, lat);
        total++;
        if ({d, z, l, o} !== {17'h000FF, 3'b000}) begin
            bad++; $display("FAIL cross_slice: D=%h z%b l%b o%b want D=000FF z0 l0 o0", d, z, l, o);
        end
        // Signed overflow.
        run_op(16'h8000, 16'h0001, 1'b0, d, z, l, o, lat);
        total++;
        if ({d, z, l, o} !== {17'h07FFF, 3'b011}) begin
            bad++; $display("FAIL overflow: D=%h z%b l%b o%b want D=07FFF z0 l1 o1", d, z, l, o);
        end
        // Equality through borrow-in.
        run_op(16'hFFFF, 16'hFFFE, 1'b1, d, z, l, o, lat);
        total++;
        if ({d, z, l, o} !== {17'h00000, 3'b100}) begin
            bad++; $display("FAIL equal_bin: D=%h z%b l%b o%b want D=00000 z1 l0 o0", d, z, l, o);
        end
        // Bin with A == B wraps to all ones and borrows.
        run_op(16'h1234, 16'h1234, 1'b1, d, z, l, o, lat);
        total++;
        if ({d, z, o} !== {17'h1FFFF, 2'b00}) begin
            bad++; $display("FAIL bin_same: D=%h z%b o%b want D=1FFFF z0 o0", d, z, o);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        A = 16'h00F0; B = 16'h000F; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        // Keep offering different operands; the block must ignore them.
        #1 A = 16'hFFFF; B = 16'h0000; Bin = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat !== 2) begin
            bad++; $display("FAIL bp_latency: got %0d want 2", lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || D !== 17'h000E1 ||
                zero !== 1'b0 || lt_s !== 1'b0 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b D=%h z%b l%b o%b want 1 0 000E1 0 0 0",
                         c, out_valid, in_ready, D, zero, lt_s, ovf);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== 17'h000E1) begin
            bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b D=%h want 0 1 000E1", out_valid, in_ready, D);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W:0] d;
        logic       z, l, o;
        int         lat;
        @(negedge clk);
        A = 16'h8000; B = 16'h0001; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || D !== 17'h0 || zero !== 1'b0 || lt_s !== 1'b0 ||
            ovf !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_run: out_valid=%b D=%h z%b l%b o%b in_ready=%b want 0 0 0 0 0 1",
                     out_valid, D, zero, lt_s, ovf, in_ready);
        end
        // A few edges under reset must not produce a result.
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_hold: out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0005, 16'h0003, 1'b0, d, z, l, o, lat);
        total++;
        if (lat !== 2 || {d, z, l, o} !== {17'h00002, 3'b000}) begin
            bad++;
            $display("FAIL post_reset: lat=%0d D=%h z%b l%b o%b want lat=2 D=00002 z0 l0 o0", lat, d, z, l, o);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Bin = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

endmodule
